// File: rtl/lcd_pkg.sv
// Shared definitions for the 4-bit HD44780 byte writer: FSM states, pin indices
// within {RS,RW,E}, and common controller command bytes.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP_H,
    S_PULSE_H,
    S_HOLD_H,
    S_SETUP_L,
    S_PULSE_L,
    S_HOLD_L,
    S_WAIT
  } state_t;

  localparam int CTRL_RS = 2;
  localparam int CTRL_RW = 1;
  localparam int CTRL_E  = 0;

  localparam logic [7:0] FUNC_SET_4BIT   = 8'h28;
  localparam logic [7:0] DISP_ON         = 8'h0F;
  localparam logic [7:0] CLEAR           = 8'h01;
  localparam logic [7:0] ENTRY_INC       = 8'h06;
  localparam logic [7:0] SET_DDRAM_LINE2 = 8'hC0;

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter shared by every timed state of the byte writer.
// Counts down to zero and parks there; zero flags the last cycle of a state.
module lcd_delay_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_byte_writer.sv
// Sends one command/data byte to a 4-bit HD44780 LCD as two E-strobed nibbles
// (or a single nibble), then waits out the controller execution time.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int CYCLES_PER_US = 50,
  parameter int T_SETUP_US    = 1,
  parameter int T_PULSE_US    = 1,
  parameter int T_HOLD_US     = 1,
  parameter int T_EXEC_US     = 100,
  parameter int T_LONG_US     = 3000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic       wr_nibble,
  input  logic       wr_long,
  input  logic [7:0] wr_data,
  output logic [2:0] ctrl_lcd,
  output logic [3:0] data_lcd,
  output logic       busy
);

  localparam int T_SETUP = T_SETUP_US * CYCLES_PER_US;
  localparam int T_PULSE = T_PULSE_US * CYCLES_PER_US;
  localparam int T_HOLD  = T_HOLD_US  * CYCLES_PER_US;
  localparam int T_EXEC  = T_EXEC_US  * CYCLES_PER_US;
  localparam int T_LONG  = T_LONG_US  * CYCLES_PER_US;
  localparam int T_MAX   = (T_LONG > T_EXEC) ? T_LONG : T_EXEC;
  localparam int CNT_W   = $clog2(T_MAX + 1);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_LONG - 1);

  if (CYCLES_PER_US < 1 || T_SETUP_US < 1 || T_PULSE_US < 1 ||
      T_HOLD_US < 1 || T_EXEC_US < 1 || T_LONG_US < 1) begin : g_bad_timing
    $error("lcd_byte_writer: every timing parameter must be >= 1");
  end

  state_t           state, state_nxt;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             zero;
  logic             accept;
  logic             rs_q, long_q;
  logic [7:0]       byte_q;
  logic [2:0]       ctrl_nxt;
  logic [3:0]       data_nxt;

  assign accept = wr_valid && wr_ready;
  assign busy   = ~wr_ready;

  lcd_delay_counter #(.CNT_W(CNT_W)) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  // Each timed state loads the counter for its successor on the way out.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_val  = '0;
    case (state)
      S_IDLE: if (accept) begin
        state_nxt = wr_nibble ? S_SETUP_L : S_SETUP_H;
        load      = 1'b1;
        load_val  = LD_SETUP;
      end
      S_SETUP_H: if (zero) begin state_nxt = S_PULSE_H; load = 1'b1; load_val = LD_PULSE; end
      S_PULSE_H: if (zero) begin state_nxt = S_HOLD_H;  load = 1'b1; load_val = LD_HOLD;  end
      S_HOLD_H:  if (zero) begin state_nxt = S_SETUP_L; load = 1'b1; load_val = LD_SETUP; end
      S_SETUP_L: if (zero) begin state_nxt = S_PULSE_L; load = 1'b1; load_val = LD_PULSE; end
      S_PULSE_L: if (zero) begin state_nxt = S_HOLD_L;  load = 1'b1; load_val = LD_HOLD;  end
      S_HOLD_L: if (zero) begin
        state_nxt = S_WAIT;
        load      = 1'b1;
        load_val  = long_q ? LD_LONG : LD_EXEC;
      end
      S_WAIT:  if (zero) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pin values decoded from the current state and registered, so pins lag the
  // state by one cycle; RW stays 0 everywhere.
  always_comb begin
    ctrl_nxt = 3'b000;
    data_nxt = data_lcd;
    case (state)
      S_SETUP_H, S_HOLD_H: begin ctrl_nxt[CTRL_RS] = rs_q; data_nxt = byte_q[7:4]; end
      S_PULSE_H: begin
        ctrl_nxt[CTRL_RS] = rs_q;
        ctrl_nxt[CTRL_E]  = 1'b1;
        data_nxt          = byte_q[7:4];
      end
      S_SETUP_L, S_HOLD_L: begin ctrl_nxt[CTRL_RS] = rs_q; data_nxt = byte_q[3:0]; end
      S_PULSE_L: begin
        ctrl_nxt[CTRL_RS] = rs_q;
        ctrl_nxt[CTRL_E]  = 1'b1;
        data_nxt          = byte_q[3:0];
      end
      S_WAIT:  data_nxt = 4'h0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wr_ready <= 1'b0;
      ctrl_lcd <= 3'b000;
      data_lcd <= 4'h0;
    end else begin
      state    <= state_nxt;
      wr_ready <= (state_nxt == S_IDLE);
      ctrl_lcd <= ctrl_nxt;
      data_lcd <= data_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rs_q   <= wr_rs;
      long_q <= wr_long;
      byte_q <= wr_data;
    end
  end

endmodule
